// File: rtl/divide_issue_control.sv
// ---------------------------------------------------------------------------
// divide_issue_control
//
// Purpose:
//   This block issues DIV/DIVU operations from the EX stage to a multi-cycle
//   divider. It holds the pipeline while the divide is in flight and commits
//   the quotient/remainder into the architectural LO/HI registers. It also
//   handles MTHI/MTLO writes.
//
//   The divider cannot be aborted. A pipeline flush during a divide therefore
//   moves the control into DRAIN, where the result is waited for and then
//   thrown away. The divider latency is not assumed; WAIT and DRAIN simply
//   sit until divide_result_valid arrives.
//
// Ports:
//   clock, reset               core clock; synchronous active-high reset
//   op_valid, op_signed        DIV/DIVU present in EX; signed select
//   op_src1, op_src2           dividend, divisor
//   flush                      pipeline flush; cancels the in-flight divide
//   mthi_valid, mtlo_valid     MTHI / MTLO write strobes
//   mt_data                    MTHI / MTLO write data
//   hi, lo                     committed HI / LO registers
//   stall                      holds EX and the younger stages
//   divide_request_valid       one-cycle request strobe to the divider
//   is_signed_input            signed select to the divider
//   input1, input2             dividend / divisor to the divider
//   divide_result_valid        divider response strobe
//   divide_result              quotient  (to LO)
//   divide_remain              remainder (to HI)
// ---------------------------------------------------------------------------
module divide_issue_control #(
  parameter int CPU_DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      op_valid,
  input  logic                      op_signed,
  input  logic [CPU_DATA_WIDTH-1:0] op_src1,
  input  logic [CPU_DATA_WIDTH-1:0] op_src2,
  input  logic                      flush,
  input  logic                      mthi_valid,
  input  logic                      mtlo_valid,
  input  logic [CPU_DATA_WIDTH-1:0] mt_data,
  output logic [CPU_DATA_WIDTH-1:0] hi,
  output logic [CPU_DATA_WIDTH-1:0] lo,
  output logic                      stall,
  output logic                      divide_request_valid,
  output logic                      is_signed_input,
  output logic [CPU_DATA_WIDTH-1:0] input1,
  output logic [CPU_DATA_WIDTH-1:0] input2,
  input  logic                      divide_result_valid,
  input  logic [CPU_DATA_WIDTH-1:0] divide_result,
  input  logic [CPU_DATA_WIDTH-1:0] divide_remain
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [CPU_DATA_WIDTH-1:0]   r_hi;
  logic [CPU_DATA_WIDTH-1:0]   r_lo;
  logic                        w_stall;
  logic                        w_request;
  logic                        w_commit;
  logic                        w_mt_allowed;

  // The request operands are passed straight through. The divider only
  // samples them in the cycle where divide_request_valid is high.
  assign input1          = op_src1;
  assign input2          = op_src2;
  assign is_signed_input = op_signed;

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_request    = 1'b0;
    w_commit     = 1'b0;
    w_mt_allowed = 1'b0;

    case (r_state)
      IDLE: begin
        w_mt_allowed = 1'b1;
        if (op_valid && !flush) begin
          w_request    = 1'b1;
          w_stall      = 1'b1;
          w_state_next = WAIT;
        end
      end

      WAIT: begin
        w_stall = 1'b1;
        // A flush takes priority over a result arriving in the same cycle.
        // The result belongs to the cancelled instruction.
        if (flush) begin
          w_state_next = DRAIN;
        end else if (divide_result_valid) begin
          w_commit     = 1'b1;
          w_state_next = DONE;
        end
      end

      DONE: begin
        // The DIV is still in EX (op_valid stays high). Release the stall
        // for one cycle so it leaves EX, and do not re-issue it.
        w_mt_allowed = 1'b1;
        w_state_next = IDLE;
      end

      DRAIN: begin
        // A new DIV must wait until the busy divider has delivered its
        // discarded result.
        w_mt_allowed = 1'b1;
        w_stall      = op_valid;
        if (divide_result_valid) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (flush) begin
      w_mt_allowed = 1'b0;
    end

    // While reset is held, present a quiet interface regardless of state.
    if (reset) begin
      w_stall      = 1'b0;
      w_request    = 1'b0;
      w_commit     = 1'b0;
      w_mt_allowed = 1'b0;
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_commit) begin
        r_lo <= divide_result;
        r_hi <= divide_remain;
      end else begin
        if (w_mt_allowed && mthi_valid) begin
          r_hi <= mt_data;
        end
        if (w_mt_allowed && mtlo_valid) begin
          r_lo <= mt_data;
        end
      end
    end
  end

  assign hi                   = r_hi;
  assign lo                   = r_lo;
  assign stall                = w_stall;
  assign divide_request_valid = w_request;

endmodule

// File: tb/tb_divide_issue_control.sv
// ---------------------------------------------------------------------------
// tb_divide_issue_control
//
// Purpose:
//   Directed, table-driven bench for divide_issue_control.
//
//   Each record describes one clock cycle. It holds the inputs driven during
//   that cycle and the outputs expected just before the closing edge. hi/lo
//   in a record are the register values during that cycle, so they show the
//   effect of the previous records.
//
//   The divider is played by the table: it supplies divide_result_valid
//   together with hand-computed quotient and remainder values.
// ---------------------------------------------------------------------------
module tb_divide_issue_control;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         op_valid;
  logic         op_signed;
  logic [W-1:0] op_src1;
  logic [W-1:0] op_src2;
  logic         flush;
  logic         mthi_valid;
  logic         mtlo_valid;
  logic [W-1:0] mt_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         stall;
  logic         divide_request_valid;
  logic         is_signed_input;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic         divide_result_valid;
  logic [W-1:0] divide_result;
  logic [W-1:0] divide_remain;

  divide_issue_control #(.CPU_DATA_WIDTH(W)) dut (
    .clock                (clock),
    .reset                (reset),
    .op_valid             (op_valid),
    .op_signed            (op_signed),
    .op_src1              (op_src1),
    .op_src2              (op_src2),
    .flush                (flush),
    .mthi_valid           (mthi_valid),
    .mtlo_valid           (mtlo_valid),
    .mt_data              (mt_data),
    .hi                   (hi),
    .lo                   (lo),
    .stall                (stall),
    .divide_request_valid (divide_request_valid),
    .is_signed_input      (is_signed_input),
    .input1               (input1),
    .input2               (input2),
    .divide_result_valid  (divide_result_valid),
    .divide_result        (divide_result),
    .divide_remain        (divide_remain)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic         ov;
    logic         os;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         fl;
    logic         mh;
    logic         ml;
    logic [W-1:0] md;
    logic         rv;
    logic [W-1:0] rr;
    logic [W-1:0] rm;
    logic         e_stall;
    logic         e_req;
    logic         e_sgn;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(
    input logic rst, input logic ov, input logic os,
    input logic [W-1:0] s1, input logic [W-1:0] s2,
    input logic fl, input logic mh, input logic ml, input logic [W-1:0] md,
    input logic rv, input logic [W-1:0] rr, input logic [W-1:0] rm,
    input logic es, input logic er, input logic esg,
    input logic [W-1:0] ehi, input logic [W-1:0] elo);
    vec_t v;
    v.rst = rst; v.ov = ov; v.os = os; v.s1 = s1; v.s2 = s2;
    v.fl = fl; v.mh = mh; v.ml = ml; v.md = md;
    v.rv = rv; v.rr = rr; v.rm = rm;
    v.e_stall = es; v.e_req = er; v.e_sgn = esg; v.e_hi = ehi; v.e_lo = elo;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  localparam logic [W-1:0] NEG7   = 32'hFFFF_FFF9;
  localparam logic [W-1:0] QS     = 32'hFFFF_FFFD;
  localparam logic [W-1:0] RS     = 32'hFFFF_FFFF;
  localparam logic [W-1:0] QU     = 32'h7FFF_FFFC;
  localparam logic [W-1:0] MTH    = 32'h1234_5678;
  localparam logic [W-1:0] CAFE   = 32'h0000_CAFE;

  initial begin
    // Each record: rst ov os s1 s2 fl mh ml md rv rr rm | stall req sgn hi lo
    // Record 0: reset held with an op present -> quiet outputs, hi=lo=0.
    vq.push_back(mk(1,1,0,100,7, 0,0,0,0, 0,0,0,        0,0,0, 0,0));
    // DIVU 100/7, op held: one request cycle, then WAIT with several cycles.
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,1,0, 0,0));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,0,0, 0,0));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,0,0, 0,0));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 1,14,2,       1,0,0, 0,0));
    // DONE: op still held, no re-issue, stall released.
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        0,0,0, 2,14));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0, 0,0,0,        0,0,0, 2,14));
    // Signed DIV 0xFFFFFFF9 / 2.
    vq.push_back(mk(0,1,1,NEG7,2, 0,0,0,0, 0,0,0,       1,1,1, 2,14));
    vq.push_back(mk(0,1,1,NEG7,2, 0,0,0,0, 1,QS,RS,     1,0,0, 2,14));
    vq.push_back(mk(0,1,1,NEG7,2, 0,0,0,0, 0,0,0,       0,0,0, RS,QS));
    // DIVU with the same operands, issued right out of DONE->IDLE.
    vq.push_back(mk(0,1,0,NEG7,2, 0,0,0,0, 0,0,0,       1,1,0, RS,QS));
    vq.push_back(mk(0,1,0,NEG7,2, 0,0,0,0, 1,QU,1,      1,0,0, RS,QS));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0, 0,0,0,        0,0,0, 1,QU));
    // Flush five cycles after the request -> DRAIN, result discarded.
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,1,0, 1,QU));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,0,0, 1,QU));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,0,0, 1,QU));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,0,0, 1,QU));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,0,0, 1,QU));
    vq.push_back(mk(0,0,0,0,0,   1,0,0,0, 0,0,0,        1,0,0, 1,QU));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0, 0,0,0,        0,0,0, 1,QU));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0, 1,32'hDEADBEEF,32'h0BADF00D, 0,0,0, 1,QU));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0, 0,0,0,        0,0,0, 1,QU));
    // New DIVU 9/4 presented during DRAIN: held, then issued from IDLE.
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,1,0, 1,QU));
    vq.push_back(mk(0,0,0,0,0,   1,0,0,0, 0,0,0,        1,0,0, 1,QU));
    vq.push_back(mk(0,1,0,9,4,   0,0,0,0, 0,0,0,        1,0,0, 1,QU));
    vq.push_back(mk(0,1,0,9,4,   0,0,0,0, 0,0,0,        1,0,0, 1,QU));
    vq.push_back(mk(0,1,0,9,4,   0,0,0,0, 1,32'hDEAD,32'hBEEF, 1,0,0, 1,QU));
    vq.push_back(mk(0,1,0,9,4,   0,0,0,0, 0,0,0,        1,1,0, 1,QU));
    vq.push_back(mk(0,1,0,9,4,   0,0,0,0, 1,2,1,        1,0,0, 1,QU));
    // DONE with flush: flush ignored, next state is IDLE (re-issue next).
    vq.push_back(mk(0,1,0,9,4,   1,0,0,0, 0,0,0,        0,0,0, 1,2));
    vq.push_back(mk(0,1,0,9,4,   0,0,0,0, 0,0,0,        1,1,0, 1,2));
    vq.push_back(mk(0,1,0,9,4,   0,0,0,0, 1,2,1,        1,0,0, 1,2));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0, 0,0,0,        0,0,0, 1,2));
    // MTHI in IDLE, MTLO under flush, MTLO during WAIT, MTHI in DONE.
    vq.push_back(mk(0,0,0,0,0,   0,1,0,MTH, 0,0,0,      0,0,0, 1,2));
    vq.push_back(mk(0,0,0,0,0,   1,0,1,32'h55555555, 0,0,0, 0,0,0, MTH,2));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,1,0, MTH,2));
    vq.push_back(mk(0,1,0,100,7, 0,0,1,32'h66666666, 0,0,0, 1,0,0, MTH,2));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 1,14,2,       1,0,0, MTH,2));
    vq.push_back(mk(0,0,0,0,0,   0,1,0,CAFE, 0,0,0,     0,0,0, 2,14));
    // Reset mid-WAIT, then a stray result in IDLE must be ignored.
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,1,0, CAFE,14));
    vq.push_back(mk(0,1,0,100,7, 0,0,0,0, 0,0,0,        1,0,0, CAFE,14));
    vq.push_back(mk(1,1,0,100,7, 0,0,0,0, 0,0,0,        0,0,0, CAFE,14));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0, 1,99,98,      0,0,0, 0,0));
    vq.push_back(mk(0,0,0,0,0,   0,0,0,0, 0,0,0,        0,0,0, 0,0));

    // Initial reset before the table starts.
    reset = 1'b1; op_valid = 0; op_signed = 0; op_src1 = '0; op_src2 = '0;
    flush = 0; mthi_valid = 0; mtlo_valid = 0; mt_data = '0;
    divide_result_valid = 0; divide_result = '0; divide_remain = '0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < vq.size(); i++) begin
      #1;
      reset               = vq[i].rst;
      op_valid            = vq[i].ov;
      op_signed           = vq[i].os;
      op_src1             = vq[i].s1;
      op_src2             = vq[i].s2;
      flush               = vq[i].fl;
      mthi_valid          = vq[i].mh;
      mtlo_valid          = vq[i].ml;
      mt_data             = vq[i].md;
      divide_result_valid = vq[i].rv;
      divide_result       = vq[i].rr;
      divide_remain       = vq[i].rm;
      #3;
      chk("stall", i, {31'd0, stall}, {31'd0, vq[i].e_stall});
      chk("req",   i, {31'd0, divide_request_valid}, {31'd0, vq[i].e_req});
      chk("hi",    i, hi, vq[i].e_hi);
      chk("lo",    i, lo, vq[i].e_lo);
      if (vq[i].e_req) begin
        chk("sgn",    i, {31'd0, is_signed_input}, {31'd0, vq[i].e_sgn});
        chk("input1", i, input1, vq[i].s1);
        chk("input2", i, input2, vq[i].s2);
      end
      $display("vec %0d: rst=%0b op=%0b fl=%0b rv=%0b -> stall=%0b req=%0b hi=%h lo=%h",
               i, vq[i].rst, vq[i].ov, vq[i].fl, vq[i].rv,
               stall, divide_request_valid, hi, lo);
      @(posedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
